// File: rtl/fp_regfile_wb.sv
// fp_regfile_wb: FP register file with single-port commit arbiter, load-writeback FIFO,
// bypassed operand reads and a RAW busy scoreboard for the issue stage.
module fp_regfile_wb #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W = 32,
  parameter int LD_FIFO_DEPTH = 2,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fpu_we_i,
  input  logic [AW-1:0]     fpu_waddr_i,
  input  logic [DATA_W-1:0] fpu_wdata_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [AW-1:0]     ld_waddr_i,
  input  logic [DATA_W-1:0] ld_wdata_i,
  input  logic [AW-1:0]     raddr1_i,
  input  logic [AW-1:0]     raddr2_i,
  input  logic [AW-1:0]     raddr3_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [DATA_W-1:0] rdata3_o,
  input  logic              issue_valid_i,
  input  logic [2:0]        issue_use_i,
  input  logic [AW-1:0]     issue_rd_i,
  output logic              issue_stall_o,
  output logic [NUM_REGS-1:0] busy_o
);
  localparam int PW = $clog2(LD_FIFO_DEPTH);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [AW-1:0] fifo_addr [LD_FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [LD_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic push, pop, commit_we;
  logic [AW-1:0] commit_addr;
  logic [DATA_W-1:0] commit_data;
  logic [NUM_REGS-1:0] busy, busy_nxt;
  logic [AW-1:0] raddr [3];
  logic [DATA_W-1:0] rdata [3];
  logic [2:0] hazard;
  // FPU results are never back-pressured; the FIFO drains only in idle FPU cycles
  assign ld_ready_o = count != (PW+1)'(LD_FIFO_DEPTH);
  assign push = ld_valid_i && ld_ready_o;
  assign pop = count != '0 && !fpu_we_i;
  assign commit_we = fpu_we_i || pop;
  assign commit_addr = fpu_we_i ? fpu_waddr_i : fifo_addr[rd_ptr];
  assign commit_data = fpu_we_i ? fpu_wdata_i : fifo_data[rd_ptr];
  assign raddr = '{raddr1_i, raddr2_i, raddr3_i};
  for (genvar k = 0; k < 3; k++) begin : g_port
    assign rdata[k] = commit_we && commit_addr == raddr[k] ? commit_data : regs[raddr[k]];
    assign hazard[k] = issue_use_i[k] && busy[raddr[k]] && !(commit_we && commit_addr == raddr[k]);
  end
  assign rdata1_o = rdata[0];
  assign rdata2_o = rdata[1];
  assign rdata3_o = rdata[2];
  assign issue_stall_o = issue_valid_i && |hazard;
  assign busy_o = busy;
  always_comb begin
    busy_nxt = busy;
    if (commit_we) busy_nxt[commit_addr] = 1'b0;
    if (issue_valid_i && !issue_stall_o) busy_nxt[issue_rd_i] = 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      busy <= busy_nxt;
      if (commit_we) regs[commit_addr] <= commit_data;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr[wr_ptr] <= ld_waddr_i;
      fifo_data[wr_ptr] <= ld_wdata_i;
    end
  end
endmodule

// File: tb/tb_fp_regfile_wb.sv
// tb_fp_regfile_wb: scenario tasks against a reference model with a load-writeback scoreboard queue.
module tb_fp_regfile_wb;
  localparam int DEPTH = 2;
  logic clk_i = 1'b0, rst_i;
  logic fpu_we_i, ld_valid_i, ld_ready_o, issue_valid_i, issue_stall_o;
  logic [4:0] fpu_waddr_i, ld_waddr_i, raddr1_i, raddr2_i, raddr3_i, issue_rd_i;
  logic [31:0] fpu_wdata_i, ld_wdata_i, rdata1_o, rdata2_o, rdata3_o, busy_o;
  logic [2:0] issue_use_i;
  typedef struct {logic [4:0] a; logic [31:0] d;} ld_t;
  ld_t sb_q[$];
  logic [31:0] exp_regs [32];
  logic [31:0] exp_busy;
  int pass_cnt = 0, total_cnt = 0;

  fp_regfile_wb dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .fpu_we_i(fpu_we_i), .fpu_waddr_i(fpu_waddr_i), .fpu_wdata_i(fpu_wdata_i),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_waddr_i(ld_waddr_i), .ld_wdata_i(ld_wdata_i),
    .raddr1_i(raddr1_i), .raddr2_i(raddr2_i), .raddr3_i(raddr3_i),
    .rdata1_o(rdata1_o), .rdata2_o(rdata2_o), .rdata3_o(rdata3_o),
    .issue_valid_i(issue_valid_i), .issue_use_i(issue_use_i), .issue_rd_i(issue_rd_i),
    .issue_stall_o(issue_stall_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic committing(input logic [4:0] a);
    return fpu_we_i ? fpu_waddr_i == a : (sb_q.size() != 0 && sb_q[0].a == a);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (fpu_we_i && fpu_waddr_i == a) return fpu_wdata_i;
    if (!fpu_we_i && sb_q.size() != 0 && sb_q[0].a == a) return sb_q[0].d;
    return exp_regs[a];
  endfunction

  function automatic logic model_stall();
    logic [4:0] ra [3];
    logic s = 1'b0;
    ra[0] = raddr1_i; ra[1] = raddr2_i; ra[2] = raddr3_i;
    for (int k = 0; k < 3; k++)
      if (issue_use_i[k] && exp_busy[ra[k]] && !committing(ra[k])) s = 1'b1;
    return issue_valid_i && s;
  endfunction

  always @(posedge clk_i) begin
    logic rdy, stl;
    ld_t e;
    if (rst_i) begin
      for (int i = 0; i < 32; i++) exp_regs[i] = '0;
      exp_busy = '0;
      sb_q.delete();
    end else begin
      rdy = sb_q.size() < DEPTH;
      stl = model_stall();
      if (fpu_we_i) begin
        exp_regs[fpu_waddr_i] = fpu_wdata_i;
        exp_busy[fpu_waddr_i] = 1'b0;
      end else if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        exp_regs[e.a] = e.d;
        exp_busy[e.a] = 1'b0;
      end
      if (issue_valid_i && !stl) exp_busy[issue_rd_i] = 1'b1;
      if (ld_valid_i && rdy) begin
        e.a = ld_waddr_i; e.d = ld_wdata_i;
        sb_q.push_back(e);
      end
    end
  end

  task automatic idle();
    fpu_we_i = 0; fpu_waddr_i = 0; fpu_wdata_i = 0;
    ld_valid_i = 0; ld_waddr_i = 0; ld_wdata_i = 0;
    raddr1_i = 0; raddr2_i = 0; raddr3_i = 0;
    issue_valid_i = 0; issue_use_i = 0; issue_rd_i = 0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    idle();
    raddr1_i = 0; raddr2_i = 5; raddr3_i = 31;
    #1;
    total_cnt++; if (rdata1_o !== 32'h0) $display("FAIL reset_rdata1 got %h exp 00000000", rdata1_o); else pass_cnt++;
    total_cnt++; if (rdata2_o !== 32'h0) $display("FAIL reset_rdata2 got %h exp 00000000", rdata2_o); else pass_cnt++;
    total_cnt++; if (rdata3_o !== 32'h0) $display("FAIL reset_rdata3 got %h exp 00000000", rdata3_o); else pass_cnt++;
    total_cnt++; if (ld_ready_o !== 1'b1) $display("FAIL reset_ready got %b exp 1", ld_ready_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 32'h0) $display("FAIL reset_busy got %h exp 00000000", busy_o); else pass_cnt++;
    total_cnt++; if (issue_stall_o !== 1'b0) $display("FAIL reset_stall got %b exp 0", issue_stall_o); else pass_cnt++;
  endtask

  task automatic test_load();
    @(negedge clk_i);
    idle();
    ld_valid_i = 1; ld_waddr_i = 1; ld_wdata_i = 32'h4023d70a;
    #1;
    total_cnt++; if (ld_ready_o !== 1'b1) $display("FAIL load_ready0 got %b exp 1", ld_ready_o); else pass_cnt++;
    @(negedge clk_i);
    ld_waddr_i = 2; ld_wdata_i = 32'h41200000; raddr1_i = 1;
    #1;
    total_cnt++; if (rdata1_o !== 32'h4023d70a) $display("FAIL load_f1_bypass got %h exp 4023d70a", rdata1_o); else pass_cnt++;
    total_cnt++; if (ld_ready_o !== 1'b1) $display("FAIL load_ready1 got %b exp 1", ld_ready_o); else pass_cnt++;
    @(negedge clk_i);
    ld_valid_i = 0; raddr1_i = 1; raddr2_i = 2;
    #1;
    total_cnt++; if (rdata2_o !== 32'h41200000) $display("FAIL load_f2_bypass got %h exp 41200000", rdata2_o); else pass_cnt++;
    total_cnt++; if (rdata1_o !== 32'h4023d70a) $display("FAIL load_f1_array got %h exp 4023d70a", rdata1_o); else pass_cnt++;
    @(negedge clk_i);
    #1;
    total_cnt++; if (rdata2_o !== 32'h41200000) $display("FAIL load_f2_array got %h exp 41200000", rdata2_o); else pass_cnt++;
  endtask

  task automatic test_raw();
    @(negedge clk_i);
    idle();
    issue_valid_i = 1; issue_use_i = 3'b000; issue_rd_i = 3;
    #1;
    total_cnt++; if (issue_stall_o !== 1'b0) $display("FAIL raw_issue_add got %b exp 0", issue_stall_o); else pass_cnt++;
    @(negedge clk_i);
    issue_use_i = 3'b011; raddr1_i = 3; raddr2_i = 0; issue_rd_i = 4;
    #1;
    total_cnt++; if (issue_stall_o !== 1'b1) $display("FAIL raw_stall got %b exp 1", issue_stall_o); else pass_cnt++;
    total_cnt++; if (busy_o[3] !== 1'b1) $display("FAIL raw_busy3_set got %b exp 1", busy_o[3]); else pass_cnt++;
    @(negedge clk_i);
    fpu_we_i = 1; fpu_waddr_i = 3; fpu_wdata_i = 32'h4148f5c3;
    #1;
    total_cnt++; if (issue_stall_o !== 1'b0) $display("FAIL raw_resolved got %b exp 0", issue_stall_o); else pass_cnt++;
    total_cnt++; if (rdata1_o !== 32'h4148f5c3) $display("FAIL raw_bypass got %h exp 4148f5c3", rdata1_o); else pass_cnt++;
    @(negedge clk_i);
    idle();
    raddr1_i = 3;
    #1;
    total_cnt++; if (busy_o[3] !== 1'b0) $display("FAIL raw_busy3_clear got %b exp 0", busy_o[3]); else pass_cnt++;
    total_cnt++; if (rdata1_o !== 32'h4148f5c3) $display("FAIL raw_f3 got %h exp 4148f5c3", rdata1_o); else pass_cnt++;
    total_cnt++; if (busy_o !== exp_busy) $display("FAIL raw_busy_vec got %h exp %h", busy_o, exp_busy); else pass_cnt++;
  endtask

  task automatic test_starve();
    logic [4:0] la [3];
    logic [31:0] lda [3];
    logic [8:0] exp_rdy = 9'b111100011;
    int idx = 0;
    la[0] = 20; la[1] = 21; la[2] = 22;
    lda[0] = 32'hc0000001; lda[1] = 32'hc0000002; lda[2] = 32'hc0000003;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk_i);
      idle();
      fpu_we_i = c < 4; fpu_waddr_i = 5'(10 + c); fpu_wdata_i = 32'h3f800000 + 32'(c);
      ld_valid_i = idx < 3;
      ld_waddr_i = idx < 3 ? la[idx] : 5'd0;
      ld_wdata_i = idx < 3 ? lda[idx] : 32'h0;
      raddr3_i = sb_q.size() != 0 ? sb_q[0].a : 5'd0;
      #1;
      total_cnt++; if (ld_ready_o !== exp_rdy[c]) $display("FAIL starve_ready c=%0d got %b exp %b", c, ld_ready_o, exp_rdy[c]); else pass_cnt++;
      total_cnt++; if (rdata3_o !== exp_read(raddr3_i)) $display("FAIL starve_head c=%0d got %h exp %h", c, rdata3_o, exp_read(raddr3_i)); else pass_cnt++;
      if (ld_valid_i && sb_q.size() < DEPTH) idx++;
    end
    @(negedge clk_i);
    idle();
    raddr1_i = 20; raddr2_i = 21; raddr3_i = 22;
    #1;
    total_cnt++; if (rdata1_o !== 32'hc0000001) $display("FAIL starve_l0 got %h exp c0000001", rdata1_o); else pass_cnt++;
    total_cnt++; if (rdata2_o !== 32'hc0000002) $display("FAIL starve_l1 got %h exp c0000002", rdata2_o); else pass_cnt++;
    total_cnt++; if (rdata3_o !== 32'hc0000003) $display("FAIL starve_l2 got %h exp c0000003", rdata3_o); else pass_cnt++;
    raddr1_i = 13;
    #1;
    total_cnt++; if (rdata1_o !== 32'h3f800003) $display("FAIL starve_fpu13 got %h exp 3f800003", rdata1_o); else pass_cnt++;
  endtask

  task automatic test_set_wins();
    @(negedge clk_i);
    idle();
    issue_valid_i = 1; issue_use_i = 3'b000; issue_rd_i = 6;
    fpu_we_i = 1; fpu_waddr_i = 6; fpu_wdata_i = 32'h40490fdb;
    #1;
    total_cnt++; if (issue_stall_o !== 1'b0) $display("FAIL setwin_stall got %b exp 0", issue_stall_o); else pass_cnt++;
    @(negedge clk_i);
    idle();
    raddr1_i = 6;
    #1;
    total_cnt++; if (busy_o[6] !== 1'b1) $display("FAIL setwin_busy6 got %b exp 1", busy_o[6]); else pass_cnt++;
    total_cnt++; if (rdata1_o !== 32'h40490fdb) $display("FAIL setwin_f6 got %h exp 40490fdb", rdata1_o); else pass_cnt++;
    total_cnt++; if (busy_o !== exp_busy) $display("FAIL setwin_busy_vec got %h exp %h", busy_o, exp_busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    idle();
    fpu_we_i = 1; fpu_waddr_i = 9; fpu_wdata_i = 32'h11111111;
    ld_valid_i = 1; ld_waddr_i = 25; ld_wdata_i = 32'h25252525;
    issue_valid_i = 1; issue_rd_i = 7;
    @(negedge clk_i);
    issue_valid_i = 0;
    ld_waddr_i = 26; ld_wdata_i = 32'h26262626;
    @(negedge clk_i);
    idle();
    rst_i = 1;
    #1;
    total_cnt++; if (ld_ready_o !== 1'b0) $display("FAIL rmid_full got %b exp 0", ld_ready_o); else pass_cnt++;
    total_cnt++; if (busy_o[7] !== 1'b1) $display("FAIL rmid_busy7 got %b exp 1", busy_o[7]); else pass_cnt++;
    @(negedge clk_i);
    rst_i = 0;
    #1;
    total_cnt++; if (ld_ready_o !== 1'b1) $display("FAIL rmid_ready got %b exp 1", ld_ready_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 32'h0) $display("FAIL rmid_busy got %h exp 00000000", busy_o); else pass_cnt++;
    repeat (3) @(negedge clk_i);
    raddr1_i = 25; raddr2_i = 26; raddr3_i = 9;
    #1;
    total_cnt++; if (rdata1_o !== 32'h0) $display("FAIL rmid_f25 got %h exp 00000000", rdata1_o); else pass_cnt++;
    total_cnt++; if (rdata2_o !== 32'h0) $display("FAIL rmid_f26 got %h exp 00000000", rdata2_o); else pass_cnt++;
    total_cnt++; if (rdata3_o !== 32'h0) $display("FAIL rmid_f9 got %h exp 00000000", rdata3_o); else pass_cnt++;
  endtask

  initial begin
    rst_i = 1;
    idle();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 0;
    test_reset();
    test_load();
    test_raw();
    test_starve();
    test_set_wins();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/fp_regfile_wb.md
Name: fp_regfile_wb

Overview:
- Floating-point register file and writeback collector for the FPU.
- Takes the FPU result write (we/addr/wdata) plus a buffered load-writeback stream. Commits at most one write per cycle.
- Serves three combinational operand read ports to the FPU issue side.
- Keeps a per-register busy scoreboard so issue stalls on RAW hazards against in-flight results.

Parameters:
- NUM_REGS, 32, number of FP registers; address width AW = $clog2(NUM_REGS).
- DATA_W, 32, register width (IEEE-754 single).
- LD_FIFO_DEPTH, 2, load-writeback buffer entries; power of two, >= 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- fpu_we_i  in  1  FPU result write strobe (same meaning as the FPU fp_regfile_write_o).
- fpu_waddr_i  in  AW  FPU destination register.
- fpu_wdata_i  in  DATA_W  FPU result.
- ld_valid_i  in  1  load writeback valid.
- ld_ready_o  out  1  load writeback ready.
- ld_waddr_i  in  AW  load destination register.
- ld_wdata_i  in  DATA_W  load data.
- raddr1_i, raddr2_i, raddr3_i  in  AW each  operand read addresses.
- rdata1_o, rdata2_o, rdata3_o  out  DATA_W each  operand read data.
- issue_valid_i  in  1  an FP instruction is presented for issue.
- issue_use_i  in  3  bit k set: operand k+1 is used.
- issue_rd_i  in  AW  destination of the issuing instruction.
- issue_stall_o  out  1  RAW hazard; the issue is not accepted this cycle.
- busy_o  out  NUM_REGS  scoreboard, for debug.

Behaviour:
- Reset (rst_i high at posedge): all registers 0x00000000, busy all 0, FIFO empty.
- Reset outputs: ld_ready_o=1 and issue_stall_o=0 in the cycle after reset; rdata reads 0.
- Reset mid-operation discards all FIFO contents and pending busy bits.
- Register 0 is an ordinary writable register; it is not hardwired to zero.

Commit arbiter:
- Exactly zero or one write per cycle.
- fpu_we_i has absolute priority and is never back-pressured.
- FIFO head commits (pop) only when the FIFO is non-empty and fpu_we_i=0.
- Commit data lands in the array at the posedge.

Read ports:
- Combinational reads.
- Write-through bypass: if raddrN_i equals the address committing in the current cycle, rdataN_o returns the committing data, not the stale array value.
- The same bypass applies to all three ports.

Load FIFO:
- Every load passes through the FIFO, so the minimum commit latency is 1 cycle after acceptance.
- Push on ld_valid_i && ld_ready_o.
- ld_ready_o = !full, based on occupancy only; a same-cycle pop does not raise ready.
- Push and pop in the same cycle leave the count unchanged.
- Pointers wrap modulo LD_FIFO_DEPTH.
- Loads are committed in arrival order.
- Sustained fpu_we_i starves the FIFO; ld_ready_o stays low until an idle FPU cycle. This is the specified behaviour.

Scoreboard:
- Set: an accepted issue (issue_valid_i && !issue_stall_o) sets busy[issue_rd_i] at the posedge.
- Clear: any commit (FPU or load) clears busy[commit addr].
- Same index set and cleared in the same cycle: set wins.

Hazard detection:
- issue_stall_o = issue_valid_i && OR over k of (issue_use_i[k] && busy[raddr(k+1)] && the register is not being committed this cycle).
- A commit in the same cycle resolves the hazard through the bypass.
- No WAW check: a second issue to a busy rd is allowed; the first commit clears the bit.

Test Plan:
- Reset, then read all three ports at addresses 0, 5 and 31 -> rdata 0x00000000; ld_ready_o=1; busy_o=0.
- Load f1=0x4023d70a (2.56) and f2=0x41200000 (10.0) on consecutive cycles -> f1 readable 1 cycle after acceptance and f2 the cycle after; ld_ready_o stays 1.
- Issue ADD with rd=3, then present an issue with use=3'b011, raddr1=3 -> issue_stall_o=1. Then fpu_we_i with waddr 3, data 0x4148f5c3 (12.56) -> same cycle: stall=0, rdata1=0x4148f5c3 via bypass; busy[3]=0 the next cycle.
- Hold fpu_we_i high for 4 cycles while driving 3 loads -> first 2 accepted, ld_ready_o=0; after fpu_we_i drops, loads commit in order one per cycle and ld_ready_o returns to 1.
- In one cycle, issue with rd=6 accepted while the FPU commits to f6 -> busy[6]=1 afterwards (set wins); f6 holds the committed data.
- Assert rst_i with the FIFO full and busy[7]=1 -> the next cycle: FIFO empty, busy all 0, buffered loads never written.
